// File: rtl/blockade_video_pkg.sv
// ---------------------------------------------------------------------------
// blockade_video_pkg
//
// Purpose: shared timing constants and helpers for the Blockade video timing
// generator. Each H and V counter stage imports this package so the raster
// geometry is defined in exactly one place.
//
// Contents:
//   CNT_W               width of the horizontal and vertical counts
//   H_TOTAL, H_ACTIVE   pixels per line / visible pixels per line
//   HS_START, HS_END    horizontal sync window [HS_START, HS_END)
//   V_TOTAL, V_ACTIVE   lines per frame / visible lines per frame
//   VS_START, VS_END    vertical sync window [VS_START, VS_END)
//   in_window()         unsigned half-open window test on a count
// ---------------------------------------------------------------------------
package blockade_video_pkg;

  localparam int unsigned CNT_W    = 9;

  localparam int unsigned H_TOTAL  = 320;
  localparam int unsigned H_ACTIVE = 256;
  localparam int unsigned HS_START = 272;
  localparam int unsigned HS_END   = 296;

  localparam int unsigned V_TOTAL  = 262;
  localparam int unsigned V_ACTIVE = 224;
  localparam int unsigned VS_START = 234;
  localparam int unsigned VS_END   = 237;

  // True when lo <= count < hi. The bounds are wider than the count so that
  // an end bound of 512 (a window running to the last count) still works.
  function automatic logic in_window(input logic [CNT_W-1:0] count,
                                     input int unsigned       lo,
                                     input int unsigned       hi);
    return (32'(count) >= lo) && (32'(count) < hi);
  endfunction

endpackage

// File: rtl/blockade_video_timing_axis.sv
// ---------------------------------------------------------------------------
// timing_axis
//
// Purpose: one axis (horizontal or vertical) of the video timing chain. A
// synchronous wrapping counter with registered sync and blank decodes and a
// combinational terminal-count strobe, equivalent to a 74163 chain plus its
// decode PROM.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   adv      in   advance enable (pixel ce for H, H terminal count for V)
//   count    out  current count, 0 .. TOTAL-1
//   sync_n   out  low while S_START <= count < S_END (registered)
//   blank    out  high while count >= ACTIVE (registered)
//   tc       out  adv & (count == TOTAL-1), forced low during reset
// ---------------------------------------------------------------------------
module timing_axis
  import blockade_video_pkg::*;
#(
  parameter int unsigned TOTAL   = H_TOTAL,
  parameter int unsigned ACTIVE  = H_ACTIVE,
  parameter int unsigned S_START = HS_START,
  parameter int unsigned S_END   = HS_END
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             adv,
  output logic [CNT_W-1:0] count,
  output logic             sync_n,
  output logic             blank,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_n_q, sync_n_d;
  logic             blank_q, blank_d;
  logic             at_last;

  // Next-state count and the decodes of that next count. Decoding the next
  // count rather than the current one is what keeps sync/blank aligned with
  // the count they describe despite being registered.
  always_comb begin
    at_last  = (count_q == LAST);
    count_d  = count_q;
    if (adv) begin
      count_d = at_last ? '0 : count_q + CNT_W'(1);
    end
    sync_n_d = ~in_window(count_d, S_START, S_END);
    blank_d  = (32'(count_d) >= ACTIVE);
  end

  // State only moves on an advance, so every output is frozen between ce
  // pulses. Reset puts the axis at count 0 with sync idle and blank low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      sync_n_q <= 1'b1;
      blank_q  <= 1'b0;
    end else if (adv) begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
      blank_q  <= blank_d;
    end
  end

  // The strobe is gated by reset_n so it cannot fire while the chain is held.
  assign tc     = reset_n & adv & at_last;
  assign count  = count_q;
  assign sync_n = sync_n_q;
  assign blank  = blank_q;

endmodule

// File: rtl/blockade_video_timing.sv
// ---------------------------------------------------------------------------
// blockade_video_timing
//
// Purpose: Blockade video timing generator. Two cascaded timing_axis stages
// produce the horizontal and vertical raster counts, sync, blanking and
// end-of-line / end-of-frame strobes for the playfield address generator and
// character shifter.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   ce        in   pixel clock enable, one clk wide
//   hcnt      out  horizontal count (9 bits)
//   vcnt      out  vertical count (9 bits)
//   hsync_n   out  horizontal sync, active low
//   vsync_n   out  vertical sync, active low
//   hblank    out  horizontal blank
//   vblank    out  vertical blank
//   line_tc   out  end-of-line strobe, ce & (hcnt == H_TOTAL-1)
//   frame_tc  out  end-of-frame strobe, line_tc & (vcnt == V_TOTAL-1)
// ---------------------------------------------------------------------------
module blockade_video_timing
  import blockade_video_pkg::*;
#(
  parameter int unsigned P_H_TOTAL  = H_TOTAL,
  parameter int unsigned P_H_ACTIVE = H_ACTIVE,
  parameter int unsigned P_HS_START = HS_START,
  parameter int unsigned P_HS_END   = HS_END,
  parameter int unsigned P_V_TOTAL  = V_TOTAL,
  parameter int unsigned P_V_ACTIVE = V_ACTIVE,
  parameter int unsigned P_VS_START = VS_START,
  parameter int unsigned P_VS_END   = VS_END
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             hblank,
  output logic             vblank,
  output logic             line_tc,
  output logic             frame_tc
);

  logic h_tc;
  logic v_tc;

  // Horizontal stage steps on every pixel enable.
  timing_axis #(
    .TOTAL   (P_H_TOTAL),
    .ACTIVE  (P_H_ACTIVE),
    .S_START (P_HS_START),
    .S_END   (P_HS_END)
  ) u_h_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (ce),
    .count   (hcnt),
    .sync_n  (hsync_n),
    .blank   (hblank),
    .tc      (h_tc)
  );

  // Vertical stage is carried by the horizontal terminal count, so its own
  // terminal count already includes ce and the end-of-line condition.
  timing_axis #(
    .TOTAL   (P_V_TOTAL),
    .ACTIVE  (P_V_ACTIVE),
    .S_START (P_VS_START),
    .S_END   (P_VS_END)
  ) u_v_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (h_tc),
    .count   (vcnt),
    .sync_n  (vsync_n),
    .blank   (vblank),
    .tc      (v_tc)
  );

  assign line_tc  = h_tc;
  assign frame_tc = v_tc;

endmodule

// File: tb/tb_blockade_video_timing.sv
// ---------------------------------------------------------------------------
// tb_blockade_video_timing
//
// Self-checking bench for blockade_video_timing. A default-geometry instance
// and a small-geometry instance share one clock. The reference model tracks
// only the number of pixel enables since reset and derives the expected
// raster position and decodes arithmetically from it.
// ---------------------------------------------------------------------------
module tb_blockade_video_timing;
  import blockade_video_pkg::*;

  typedef struct packed {
    int ht;
    int ha;
    int hss;
    int hse;
    int vt;
    int va;
    int vss;
    int vse;
  } tparams_t;

  localparam int S_HT = 12, S_HA = 8, S_HSS = 9, S_HSE = 11;
  localparam int S_VT = 6,  S_VA = 4, S_VSS = 4, S_VSE = 5;

  logic       clk;
  logic       resetN, ce;
  logic [8:0] hcnt, vcnt;
  logic       hsyncN, vsyncN, hblank, vblank, lineTc, frameTc;

  logic       resetSmallN, ceSmall;
  logic [8:0] hcntS, vcntS;
  logic       hsyncNS, vsyncNS, hblankS, vblankS, lineTcS, frameTcS;

  tparams_t mainP, smallP;
  int pM, pS;
  int cyc;
  int checks, errors;
  int lineTcCount, mainFtcCount, ftcH, ftcV;
  int smallFtcCycles[$];

  blockade_video_timing dut (
    .clk      (clk),
    .reset_n  (resetN),
    .ce       (ce),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .hsync_n  (hsyncN),
    .vsync_n  (vsyncN),
    .hblank   (hblank),
    .vblank   (vblank),
    .line_tc  (lineTc),
    .frame_tc (frameTc)
  );

  blockade_video_timing #(
    .P_H_TOTAL  (S_HT),
    .P_H_ACTIVE (S_HA),
    .P_HS_START (S_HSS),
    .P_HS_END   (S_HSE),
    .P_V_TOTAL  (S_VT),
    .P_V_ACTIVE (S_VA),
    .P_VS_START (S_VSS),
    .P_VS_END   (S_VSE)
  ) dutSmall (
    .clk      (clk),
    .reset_n  (resetSmallN),
    .ce       (ceSmall),
    .hcnt     (hcntS),
    .vcnt     (vcntS),
    .hsync_n  (hsyncNS),
    .vsync_n  (vsyncNS),
    .hblank   (hblankS),
    .vblank   (vblankS),
    .line_tc  (lineTcS),
    .frame_tc (frameTcS)
  );

  // Free-running 100 MHz-style clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] z1(input logic b);
    return {31'b0, b};
  endfunction

  function automatic logic [31:0] z9(input logic [8:0] v);
    return {23'b0, v};
  endfunction

  // Single comparison point: counts every check and reports failures.
  task automatic checkOne(input string tag, input string name,
                          input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      if (errors <= 30)
        $error("[TB] FAIL %s.%s: observed %0d expected %0d", tag, name, obs, exp);
    end
  endtask

  // Compares every output of one instance with the raster position implied
  // by p pixel enables since reset.
  task automatic checkOutput(input string tag, input tparams_t tp, input int p,
                             input logic rstN, input logic ceV,
                             input logic [8:0] h, input logic [8:0] v,
                             input logic hs, input logic vs,
                             input logic hb, input logic vb,
                             input logic ltc, input logic ftc);
    int   eh, ev;
    logic eLtc, eFtc;
    eh   = p % tp.ht;
    ev   = p / tp.ht;
    eLtc = rstN && ceV && (eh == tp.ht - 1);
    eFtc = eLtc && (ev == tp.vt - 1);
    checkOne(tag, "hcnt",     z9(h),   eh);
    checkOne(tag, "vcnt",     z9(v),   ev);
    checkOne(tag, "hsync_n",  z1(hs),  z1(!(eh >= tp.hss && eh < tp.hse)));
    checkOne(tag, "vsync_n",  z1(vs),  z1(!(ev >= tp.vss && ev < tp.vse)));
    checkOne(tag, "hblank",   z1(hb),  z1(eh >= tp.ha));
    checkOne(tag, "vblank",   z1(vb),  z1(ev >= tp.va));
    checkOne(tag, "line_tc",  z1(ltc), z1(eLtc));
    checkOne(tag, "frame_tc", z1(ftc), z1(eFtc));
  endtask

  // One clk cycle: drive enables after the falling edge, check both
  // instances mid-cycle, then advance the models at the rising edge.
  task automatic applyStimulus(input logic ceM, input logic ceSm);
    @(negedge clk);
    ce      = ceM;
    ceSmall = ceSm;
    #1;
    checkOutput("main", mainP, pM, resetN, ceM, hcnt, vcnt,
                hsyncN, vsyncN, hblank, vblank, lineTc, frameTc);
    checkOutput("small", smallP, pS, resetSmallN, ceSm, hcntS, vcntS,
                hsyncNS, vsyncNS, hblankS, vblankS, lineTcS, frameTcS);
    if (lineTc === 1'b1) lineTcCount++;
    if (frameTc === 1'b1) begin
      mainFtcCount++;
      ftcH = int'(hcnt);
      ftcV = int'(vcnt);
    end
    if (frameTcS === 1'b1) smallFtcCycles.push_back(cyc);
    @(posedge clk);
    cyc++;
    if (ceM && resetN) pM = (pM + 1) % (mainP.ht * mainP.vt);
    if (ceSm && resetSmallN) pS = (pS + 1) % (smallP.ht * smallP.vt);
  endtask

  // Directed sequence with randomized enable density in the first line.
  initial begin
    int n;
    logic r;
    mainP  = '{int'(H_TOTAL), int'(H_ACTIVE), int'(HS_START), int'(HS_END),
               int'(V_TOTAL), int'(V_ACTIVE), int'(VS_START), int'(VS_END)};
    smallP = '{S_HT, S_HA, S_HSS, S_HSE, S_VT, S_VA, S_VSS, S_VSE};
    checks = 0; errors = 0; cyc = 0;
    pM = 0; pS = 0;
    lineTcCount = 0; mainFtcCount = 0; ftcH = -1; ftcV = -1;
    resetN = 1'b0; resetSmallN = 1'b0;
    ce = 1'b0; ceSmall = 1'b0;

    $display("[TB] reset held with ce high");
    repeat (4) applyStimulus(1'b1, 1'b1);
    #2;
    resetN      = 1'b1;
    resetSmallN = 1'b1;

    $display("[TB] first line with random ce");
    lineTcCount = 0;
    n = 0;
    while (n < 320) begin
      r = ($urandom_range(0, 3) != 0);
      applyStimulus(r, 1'b0);
      if (r) n++;
    end
    #1;
    checkOne("line1", "hcnt", z9(hcnt), 0);
    checkOne("line1", "vcnt", z9(vcnt), 1);
    checkOne("line1", "line_tc_pulses", lineTcCount, 1);

    $display("[TB] hold at hcnt=100");
    repeat (100) applyStimulus(1'b1, 1'b0);
    repeat (50) applyStimulus(1'b0, 1'b0);
    #1;
    checkOne("hold", "hcnt", z9(hcnt), 100);
    checkOne("hold", "vcnt", z9(vcnt), 1);

    $display("[TB] rest of frame with ce high");
    mainFtcCount = 0;
    n = mainP.ht * mainP.vt - pM;
    repeat (n) applyStimulus(1'b1, 1'b0);
    #1;
    checkOne("frame", "frame_tc_pulses", mainFtcCount, 1);
    checkOne("frame", "ftc_hcnt", ftcH, 319);
    checkOne("frame", "ftc_vcnt", ftcV, 261);
    checkOne("frame", "hcnt_after", z9(hcnt), 0);
    checkOne("frame", "vcnt_after", z9(vcnt), 0);

    $display("[TB] async reset inside hsync pulse");
    repeat (280) applyStimulus(1'b1, 1'b0);
    #1;
    checkOne("preReset", "hsync_n", z1(hsyncN), 0);
    #2;
    resetN = 1'b0;
    #1;
    checkOne("asyncReset", "hcnt", z9(hcnt), 0);
    checkOne("asyncReset", "vcnt", z9(vcnt), 0);
    checkOne("asyncReset", "hsync_n", z1(hsyncN), 1);
    checkOne("asyncReset", "hblank", z1(hblank), 0);
    pM = 0;
    repeat (2) applyStimulus(1'b1, 1'b0);
    #2;
    resetN = 1'b1;

    $display("[TB] small geometry: two frames with ce high");
    repeat (2 * S_HT * S_VT + 5) applyStimulus(1'b0, 1'b1);
    checkOne("smallPeriod", "pulses", smallFtcCycles.size(), 2);
    if (smallFtcCycles.size() >= 2)
      checkOne("smallPeriod", "period", smallFtcCycles[1] - smallFtcCycles[0], S_HT * S_VT);

    $display("[TB] small geometry: async reset inside both sync pulses");
    n = 0;
    while (pS != 4 * S_HT + 10 && n < 200) begin
      applyStimulus(1'b0, 1'b1);
      n++;
    end
    #1;
    checkOne("smallPre", "hsync_n", z1(hsyncNS), 0);
    checkOne("smallPre", "vsync_n", z1(vsyncNS), 0);
    #2;
    resetSmallN = 1'b0;
    #1;
    checkOne("smallReset", "hcnt", z9(hcntS), 0);
    checkOne("smallReset", "vcnt", z9(vcntS), 0);
    checkOne("smallReset", "hsync_n", z1(hsyncNS), 1);
    checkOne("smallReset", "vsync_n", z1(vsyncNS), 1);
    checkOne("smallReset", "vblank", z1(vblankS), 0);
    pS = 0;
    repeat (3) applyStimulus(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
